// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the TX path scheduler.
//   tx_mode_e        : encoding of the 2-bit path-select control input
//   tx_sched_state_e : scheduler FSM states (also exported on the debug bus)
//   TX_DW            : default data word width
//   TX_VEC_LEN       : default frame length in words
package tx_sched_pkg;

  typedef enum logic [1:0] {
    MODE_OFF = 2'b00,
    MODE_RAW = 2'b01,
    MODE_SM  = 2'b10,
    MODE_ILL = 2'b11
  } tx_mode_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_RAW      = 2'b01,
    S_SM_FEED  = 2'b10,
    S_SM_DRAIN = 2'b11
  } tx_sched_state_e;

  localparam int TX_DW      = 16;
  localparam int TX_VEC_LEN = 8;

endpackage

// File: rtl/tx_path_sched_if.sv
// Bundle of every signal the TX path scheduler exchanges with the TX FIFO
// read side, the softmax engine and the UART transmitter.
//
// Handshake semantics (all three sources are fall-through FIFO style):
//   data is valid whenever the matching *_empty is 0; a consumer requests a
//   word with *_rd_en; a pop happens on the rising clock edge where rd_en=1
//   and empty=0. A request against an empty source is a no-op.
//
// Modports:
//   master : the scheduler (drives pops toward the FIFO / softmax output and
//            presents sources toward the softmax input / UART)
//   slave  : the surrounding blocks / testbench
// Debug: dbg_state, dbg_mode and dbg_cnt mirror the scheduler registers.
interface tx_path_sched_if
  import tx_sched_pkg::*;
#(
  parameter int DW = TX_DW
);
  logic [1:0]      control;
  logic [DW-1:0]   fifo_data;
  logic            fifo_empty;
  logic            fifo_rd_en;
  logic [DW-1:0]   sm_in_data;
  logic            sm_in_empty;
  logic            sm_in_rd_en;
  logic [DW-1:0]   sm_out_data;
  logic            sm_out_empty;
  logic            sm_out_rd_en;
  logic [DW-1:0]   uart_data;
  logic            uart_empty;
  logic            uart_rd_en;
  logic            busy;
  logic            frame_done;
  logic            err_mode;
  tx_sched_state_e dbg_state;
  logic [1:0]      dbg_mode;
  logic [7:0]      dbg_cnt;

  modport master (
    input  control, fifo_data, fifo_empty, sm_in_rd_en,
           sm_out_data, sm_out_empty, uart_rd_en,
    output fifo_rd_en, sm_in_data, sm_in_empty, sm_out_rd_en,
           uart_data, uart_empty, busy, frame_done, err_mode,
           dbg_state, dbg_mode, dbg_cnt
  );

  modport slave (
    output control, fifo_data, fifo_empty, sm_in_rd_en,
           sm_out_data, sm_out_empty, uart_rd_en,
    input  fifo_rd_en, sm_in_data, sm_in_empty, sm_out_rd_en,
           uart_data, uart_empty, busy, frame_done, err_mode,
           dbg_state, dbg_mode, dbg_cnt
  );

endinterface

// File: rtl/frame_counter.sv
// Word counter for one frame.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   i_clr    : synchronous clear (held while the scheduler is idle)
//   i_inc    : one valid pop this cycle
//   o_cnt    : words popped so far in the current frame
//   o_last   : the next valid pop is the final word of the frame
// The counter returns to zero on the terminal pop instead of wrapping, so a
// one-word frame finishes on its single pop.
module frame_counter
  import tx_sched_pkg::*;
#(
  parameter int VEC_LEN = TX_VEC_LEN,
  parameter int CW      = $clog2(VEC_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt,
  output logic          o_last
);

  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/tx_path_sched.sv
// TX path scheduler: owns the single TX FIFO read port and lends it, one
// fixed-length frame at a time, either straight to the UART (raw) or to the
// softmax engine, whose results are then forwarded to the UART.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : tx_path_sched_if.master (control, FIFO read side, softmax
//              input/output sides, UART source side, status and debug)
// Path selection is sampled only in IDLE, so a frame is never split between
// paths; IDLE always lasts at least one cycle between frames.
module tx_path_sched
  import tx_sched_pkg::*;
#(
  parameter int VEC_LEN = TX_VEC_LEN,
  parameter int DW      = TX_DW
) (
  input  logic            clk,
  input  logic            rst,
  tx_path_sched_if.master bus
);

  localparam int CW = $clog2(VEC_LEN + 1);

  tx_sched_state_e r_state;
  tx_mode_e        r_mode_q;
  logic            r_frame_done;
  logic            r_err_mode;

  logic [CW-1:0]   w_cnt;
  logic            w_last;
  logic            w_pop;
  logic            w_fifo_rd_en;
  logic            w_sm_in_empty;
  logic            w_sm_out_rd_en;
  logic            w_uart_empty;
  logic [DW-1:0]   w_uart_data;

  frame_counter #(
    .VEC_LEN (VEC_LEN),
    .CW      (CW)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state == S_IDLE),
    .i_inc  (w_pop),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  // Routing is purely combinational from the state register. Every consumer
  // other than the one owning the current phase sees an empty source, which
  // is what keeps the FIFO from ever getting two pops in one cycle.
  always_comb begin
    w_fifo_rd_en   = 1'b0;
    w_sm_in_empty  = 1'b1;
    w_sm_out_rd_en = 1'b0;
    w_uart_empty   = 1'b1;
    w_uart_data    = bus.fifo_data;
    w_pop          = 1'b0;
    unique case (r_state)
      S_RAW: begin
        w_uart_empty = bus.fifo_empty;
        w_fifo_rd_en = bus.uart_rd_en & ~bus.fifo_empty;
        w_pop        = w_fifo_rd_en;
      end
      S_SM_FEED: begin
        w_sm_in_empty = bus.fifo_empty;
        w_fifo_rd_en  = bus.sm_in_rd_en & ~bus.fifo_empty;
        w_pop         = w_fifo_rd_en;
      end
      S_SM_DRAIN: begin
        w_uart_data    = bus.sm_out_data;
        w_uart_empty   = bus.sm_out_empty;
        w_sm_out_rd_en = bus.uart_rd_en & ~bus.sm_out_empty;
        w_pop          = w_sm_out_rd_en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mode_q     <= MODE_OFF;
      r_frame_done <= 1'b0;
      r_err_mode   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          unique case (tx_mode_e'(bus.control))
            MODE_RAW: begin
              r_mode_q <= MODE_RAW;
              r_state  <= S_RAW;
            end
            MODE_SM: begin
              r_mode_q <= MODE_SM;
              r_state  <= S_SM_FEED;
            end
            MODE_ILL: r_err_mode <= 1'b1;
            default: ;
          endcase
        end
        S_RAW: begin
          if (w_pop && w_last) begin
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_SM_FEED: begin
          // Feeding the engine is only half the frame: no frame_done here.
          if (w_pop && w_last) r_state <= S_SM_DRAIN;
        end
        S_SM_DRAIN: begin
          if (w_pop && w_last) begin
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en   = w_fifo_rd_en;
  assign bus.sm_in_data   = bus.fifo_data;
  assign bus.sm_in_empty  = w_sm_in_empty;
  assign bus.sm_out_rd_en = w_sm_out_rd_en;
  assign bus.uart_data    = w_uart_data;
  assign bus.uart_empty   = w_uart_empty;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.frame_done   = r_frame_done;
  assign bus.err_mode     = r_err_mode;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_mode     = r_mode_q;
  assign bus.dbg_cnt      = 8'(w_cnt);

endmodule

// File: tb/tb_tx_path_sched.sv
// Self-checking bench for tx_path_sched: FIFO and softmax stubs, a
// scoreboard of expected UART / softmax-input words, directed scenarios and
// randomized frames.
module tb_tx_path_sched;
  import tx_sched_pkg::*;

  localparam int DW      = 16;
  localparam int VEC_LEN = 8;
  localparam logic [DW-1:0] SM_KEY = 16'h5A5A;  // softmax stub: result = word ^ SM_KEY

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_path_sched_if #(.DW(DW)) bus ();

  tx_path_sched #(.VEC_LEN(VEC_LEN), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment state.
  logic [DW-1:0] feed_q[$];    // words waiting to enter the TX FIFO
  logic [DW-1:0] fifo_q[$];    // TX FIFO contents
  logic [DW-1:0] smo_q[$];     // softmax result FIFO contents
  logic [DW:0]   exp_q[$];     // expected UART words, bit DW = last of frame
  logic [DW-1:0] exp_sm_q[$];  // expected softmax-input words
  int uart_pct = 0, sm_pct = 0, feed_pct = 100;
  int n_checks = 0, n_errors = 0;
  int n_uart_pops = 0, n_done = 0, frames_exp = 0;
  bit done_due = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO / softmax stubs and consumer request drivers.
  initial begin
    logic f_pop, s_in_pop, s_out_pop;
    logic [DW-1:0] s_in_w;
    bus.fifo_data = '0; bus.fifo_empty = 1'b1;
    bus.sm_out_data = '0; bus.sm_out_empty = 1'b1;
    bus.uart_rd_en = 1'b0; bus.sm_in_rd_en = 1'b0;
    forever begin
      @(posedge clk);
      f_pop = bus.fifo_rd_en;
      s_in_pop = bus.sm_in_rd_en && !bus.sm_in_empty;
      s_in_w = bus.sm_in_data;
      s_out_pop = bus.sm_out_rd_en;
      #1;
      if (f_pop) begin
        check("fifo_pop_nonempty", fifo_q.size() != 0, 1);
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      if (s_in_pop) smo_q.push_back(s_in_w ^ SM_KEY);
      if (s_out_pop) begin
        check("sm_out_pop_nonempty", smo_q.size() != 0, 1);
        if (smo_q.size() != 0) void'(smo_q.pop_front());
      end
      if (feed_q.size() != 0 && $urandom_range(1, 100) <= feed_pct)
        fifo_q.push_back(feed_q.pop_front());
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
      bus.sm_out_empty = (smo_q.size() == 0);
      bus.sm_out_data = (smo_q.size() != 0) ? smo_q[0] : DW'($urandom);
      bus.uart_rd_en = ($urandom_range(1, 100) <= uart_pct);
      bus.sm_in_rd_en = ($urandom_range(1, 100) <= sm_pct);
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [DW:0] e;
    logic [DW-1:0] es;
    if (rst) begin
      done_due = 1'b0;
    end else begin
      check("frame_done", bus.frame_done, done_due);
      if (done_due) check("busy_after_frame", bus.busy, 0);
      if (bus.frame_done) n_done++;
      done_due = 1'b0;
      check("single_fifo_consumer", !bus.uart_empty && !bus.sm_in_empty, 0);
      check("single_pop_source", bus.fifo_rd_en && bus.sm_out_rd_en, 0);
      if (bus.uart_rd_en && !bus.uart_empty) begin
        n_uart_pops++;
        if (exp_q.size() == 0) begin
          check("uart_unexpected_word", {16'h0, bus.uart_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("uart_data", bus.uart_data, e[DW-1:0]);
          done_due = e[DW];
        end
      end
      if (bus.sm_in_rd_en && !bus.sm_in_empty) begin
        if (exp_sm_q.size() == 0) begin
          check("sm_in_unexpected_word", {16'h0, bus.sm_in_data}, 32'hFFFF_FFFF);
        end else begin
          es = exp_sm_q.pop_front();
          check("sm_in_data", bus.sm_in_data, es);
        end
      end
    end
  end

  task automatic push_word(input logic [1:0] mode, input logic [DW-1:0] w, input bit last);
    if (mode == 2'b01) begin
      exp_q.push_back({last, w});
    end else begin
      exp_sm_q.push_back(w);
      exp_q.push_back({last, w ^ SM_KEY});
    end
    feed_q.push_back(w);
  endtask

  task automatic wait_busy(input logic v, input int bound, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (bus.busy === v) begin ok = 1'b1; break; end
    end
    check(name, ok, 1);
  endtask

  task automatic wait_pops(input int target, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk); #1;
      if (n_uart_pops >= target) begin ok = 1'b1; break; end
    end
    check(name, ok, 1);
  endtask

  task automatic flush_env();
    feed_q.delete(); fifo_q.delete(); smo_q.delete();
    exp_q.delete(); exp_sm_q.delete();
  endtask

  task automatic start_frame(input logic [1:0] mode);
    bus.control = mode;
    wait_busy(1'b1, 20, "frame_start");
    bus.control = 2'b00;
  endtask

  initial begin
    int base;
    logic [1:0] mode;
    bus.control = 2'b00;

    // Reset values, with a live FIFO word and consumers requesting.
    feed_q.push_back(16'hBEEF);
    uart_pct = 100; sm_pct = 100;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_uart_empty", bus.uart_empty, 1);
    check("rst_sm_in_empty", bus.sm_in_empty, 1);
    check("rst_fifo_rd_en", bus.fifo_rd_en, 0);
    check("rst_sm_out_rd_en", bus.sm_out_rd_en, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_err_mode", bus.err_mode, 0);
    check("rst_cnt", bus.dbg_cnt, 0);
    check("rst_sm_in_passthru", bus.sm_in_data, 16'hBEEF);
    flush_env();
    uart_pct = 0; sm_pct = 0;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // Raw frame 0x0001..0x0008 with the UART popping every cycle.
    for (int i = 0; i < VEC_LEN; i++) push_word(2'b01, DW'(i + 1), i == VEC_LEN - 1);
    repeat (VEC_LEN + 2) @(negedge clk);
    uart_pct = 100;
    start_frame(2'b01);
    wait_busy(1'b0, 200, "raw_frame_end");
    frames_exp++;
    check("raw_all_words", exp_q.size(), 0);
    uart_pct = 0;
    repeat (2) @(negedge clk);

    // Softmax frame: results 0x1000..0x1007, FIFO untouched during drain.
    for (int i = 0; i < VEC_LEN; i++) push_word(2'b10, DW'(16'h1000 + i) ^ SM_KEY, i == VEC_LEN - 1);
    repeat (VEC_LEN + 2) @(negedge clk);
    sm_pct = 100;
    start_frame(2'b10);
    for (int k = 0; k < 100 && exp_sm_q.size() != 0; k++) @(negedge clk);
    check("sm_feed_complete", exp_sm_q.size(), 0);
    feed_q.push_back(16'hDEAD);  // decoy word that must not be popped
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("drain_fifo_rd_en", bus.fifo_rd_en, 0);
      check("drain_sm_in_empty", bus.sm_in_empty, 1);
      check("drain_busy", bus.busy, 1);
    end
    uart_pct = 100;
    wait_busy(1'b0, 200, "sm_frame_end");
    frames_exp++;
    check("sm_all_words", exp_q.size(), 0);
    fifo_q.delete();
    uart_pct = 0; sm_pct = 0;
    repeat (2) @(negedge clk);

    // control 01 -> 10 after 3 raw pops: frame stays raw, then SM after IDLE.
    for (int i = 0; i < VEC_LEN; i++) push_word(2'b01, DW'($urandom), i == VEC_LEN - 1);
    repeat (VEC_LEN + 2) @(negedge clk);
    uart_pct = 100; sm_pct = 100;
    base = n_uart_pops;
    start_frame(2'b01);
    wait_pops(base + 3, "switch_3_pops");
    bus.control = 2'b10;
    wait_busy(1'b0, 200, "switch_raw_end");
    frames_exp++;
    check("switch_raw_words", exp_q.size(), 0);
    wait_busy(1'b1, 5, "switch_sm_start");
    bus.control = 2'b00;
    for (int i = 0; i < VEC_LEN; i++) push_word(2'b10, DW'($urandom), i == VEC_LEN - 1);
    wait_busy(1'b0, 300, "switch_sm_end");
    frames_exp++;
    uart_pct = 0; sm_pct = 0;
    repeat (2) @(negedge clk);

    // UART requesting against an empty FIFO for 10 cycles mid-frame.
    for (int i = 0; i < 3; i++) push_word(2'b01, DW'($urandom), 1'b0);
    repeat (5) @(negedge clk);
    uart_pct = 100;
    base = n_uart_pops;
    start_frame(2'b01);
    wait_pops(base + 3, "stall_3_pops");
    @(posedge clk); #2;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_fifo_rd_en", bus.fifo_rd_en, 0);
      check("stall_cnt", bus.dbg_cnt, 3);
      check("stall_busy", bus.busy, 1);
    end
    for (int i = 3; i < VEC_LEN; i++) push_word(2'b01, DW'($urandom), i == VEC_LEN - 1);
    wait_busy(1'b0, 200, "stall_frame_end");
    frames_exp++;
    uart_pct = 0;
    repeat (2) @(negedge clk);

    // Illegal control in IDLE: sticky error, no pops, cleared by reset.
    feed_q.push_back(16'h1234);
    uart_pct = 100; sm_pct = 100;
    repeat (3) @(negedge clk);
    bus.control = 2'b11;
    @(negedge clk);
    check("err_set", bus.err_mode, 1);
    bus.control = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("err_sticky", bus.err_mode, 1);
      check("err_busy", bus.busy, 0);
      check("err_fifo_rd_en", bus.fifo_rd_en, 0);
      check("err_sm_out_rd_en", bus.sm_out_rd_en, 0);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("err_cleared_by_rst", bus.err_mode, 0);
    @(negedge clk);
    flush_env();
    uart_pct = 0; sm_pct = 0;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset after 4 raw pops, then a full new frame.
    for (int i = 0; i < VEC_LEN; i++) push_word(2'b01, DW'($urandom), i == VEC_LEN - 1);
    repeat (VEC_LEN + 2) @(negedge clk);
    uart_pct = 100;
    base = n_uart_pops;
    start_frame(2'b01);
    wait_pops(base + 4, "arst_4_pops");
    @(posedge clk); #2;
    check("arst_pre_cnt", bus.dbg_cnt, 4);
    rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_uart_empty", bus.uart_empty, 1);
    check("arst_fifo_rd_en", bus.fifo_rd_en, 0);
    check("arst_cnt", bus.dbg_cnt, 0);
    check("arst_state", bus.dbg_state, S_IDLE);
    flush_env();
    repeat (2) @(negedge clk);
    flush_env();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < VEC_LEN; i++) push_word(2'b01, DW'($urandom), i == VEC_LEN - 1);
    repeat (VEC_LEN + 2) @(negedge clk);
    start_frame(2'b01);
    wait_busy(1'b0, 200, "arst_new_frame_end");
    frames_exp++;
    check("arst_new_frame_words", exp_q.size(), 0);
    uart_pct = 0;
    repeat (2) @(negedge clk);

    // Randomized frames with random back-pressure and ignored busy-time control.
    for (int f = 0; f < 30; f++) begin
      uart_pct = $urandom_range(30, 100);
      sm_pct = $urandom_range(30, 100);
      feed_pct = $urandom_range(30, 100);
      mode = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      bus.control = mode;
      wait_busy(1'b1, 20, "rand_frame_start");
      bus.control = 2'($urandom_range(0, 3));
      for (int i = 0; i < VEC_LEN; i++) begin
        if (i == VEC_LEN - 1) begin
          bus.control = 2'b00;
          @(negedge clk);
        end
        push_word(mode, DW'($urandom), i == VEC_LEN - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_busy(1'b0, 2000, "rand_frame_end");
      frames_exp++;
      check("rand_uart_words", exp_q.size(), 0);
      check("rand_sm_words", exp_sm_q.size(), 0);
      check("rand_err_mode", bus.err_mode, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("frame_done_count", n_done, frames_exp);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends with a summary.
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
